// File: rtl/matrix_pkg.sv
// Shared dimensions, types and width helper for the matrix MAC slice.
package matrix_pkg;

  localparam int DEF_AROWS     = 3;
  localparam int DEF_ACOLUMNS  = 3;
  localparam int DEF_BCOLUMNS  = 3;
  localparam int DEF_WIDTH_BIT = 32;

  typedef logic [DEF_WIDTH_BIT-1:0] index_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Full product width plus enough guard bits for a dot product of 'columns' terms
  function automatic int acc_width(input int width_bit, input int columns);
    return 2 * width_bit + $clog2(columns);
  endfunction

endpackage

// File: rtl/matrix_mul_stage.sv
// Registered signed multiply stage; advances only when en is high.
module matrix_mul_stage
  import matrix_pkg::*;
#(
  parameter int ACOLUMNS  = DEF_ACOLUMNS,
  parameter int WIDTH_BIT = DEF_WIDTH_BIT
) (
  input  logic                          clock,
  input  logic                          nreset,
  input  logic                          en,
  input  logic                          load,
  input  logic [WIDTH_BIT-1:0]          a_data,
  input  logic [WIDTH_BIT-1:0]          b_data,
  input  logic [WIDTH_BIT-1:0]          i,
  input  logic [WIDTH_BIT-1:0]          j,
  input  logic [WIDTH_BIT-1:0]          k,
  output logic                          s1_valid,
  output logic                          s1_first,
  output logic                          s1_last,
  output logic signed [2*WIDTH_BIT-1:0] s1_prod,
  output logic [WIDTH_BIT-1:0]          s1_i,
  output logic [WIDTH_BIT-1:0]          s1_j
);

  localparam int PW = 2 * WIDTH_BIT;

  // Capture product and beat tags on advance; a cycle without a beat loads a bubble
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_i     <= '0;
      s1_j     <= '0;
    end else if (en) begin
      s1_valid <= load;
      if (load) begin
        s1_prod  <= PW'($signed(a_data)) * PW'($signed(b_data));
        s1_first <= (k == '0);
        s1_last  <= (k == WIDTH_BIT'(ACOLUMNS - 1));
        s1_i     <= i;
        s1_j     <= j;
      end
    end
  end

endmodule

// File: rtl/matrix_mac_accumulator.sv
// Streaming multiply-accumulate producing C = A x B one element per dot product.
module matrix_mac_accumulator
  import matrix_pkg::*;
#(
  parameter int AROWS     = DEF_AROWS,
  parameter int ACOLUMNS  = DEF_ACOLUMNS,
  parameter int BCOLUMNS  = DEF_BCOLUMNS,
  parameter int WIDTH_BIT = DEF_WIDTH_BIT
) (
  input  logic                                       clock,
  input  logic                                       nreset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [WIDTH_BIT-1:0]                       a_data,
  input  logic [WIDTH_BIT-1:0]                       b_data,
  input  logic [WIDTH_BIT-1:0]                       i,
  input  logic [WIDTH_BIT-1:0]                       j,
  input  logic [WIDTH_BIT-1:0]                       k,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [acc_width(WIDTH_BIT, ACOLUMNS)-1:0]  c_data,
  output logic [WIDTH_BIT-1:0]                       c_i,
  output logic [WIDTH_BIT-1:0]                       c_j,
  output logic                                       done,
  output logic                                       seq_err
);

  localparam int ACC_W = acc_width(WIDTH_BIT, ACOLUMNS);
  localparam int PW    = 2 * WIDTH_BIT;
  localparam int NRES  = AROWS * BCOLUMNS;

  logic                    adv, accept, last_in, restart_err;
  logic [WIDTH_BIT-1:0]    exp_k, k_next, res_cnt;
  logic                    s1_valid, s1_first, s1_last;
  logic signed [PW-1:0]    s1_prod;
  logic [WIDTH_BIT-1:0]    s1_i, s1_j;
  logic                    s2_valid, s2_last;
  logic [WIDTH_BIT-1:0]    s2_i, s2_j;
  logic signed [ACC_W-1:0] acc, prod_ext, acc_next;
  state_t                  state, state_next;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign last_in  = (k == WIDTH_BIT'(ACOLUMNS - 1));
  assign k_next   = last_in ? '0 : k + 1'b1;

  matrix_mul_stage #(
    .ACOLUMNS  (ACOLUMNS),
    .WIDTH_BIT (WIDTH_BIT)
  ) u_mul (
    .clock    (clock),
    .nreset   (nreset),
    .en       (adv),
    .load     (accept),
    .a_data   (a_data),
    .b_data   (b_data),
    .i        (i),
    .j        (j),
    .k        (k),
    .s1_valid (s1_valid),
    .s1_first (s1_first),
    .s1_last  (s1_last),
    .s1_prod  (s1_prod),
    .s1_i     (s1_i),
    .s1_j     (s1_j)
  );

  assign prod_ext = ACC_W'(s1_prod);
  assign acc_next = s1_first ? prod_ext : acc + prod_ext;

  // Stage 2: accumulator, restarted by every k==0 beat
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_i     <= '0;
      s2_j     <= '0;
      acc      <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        acc     <= acc_next;
        s2_last <= s1_last;
        s2_i    <= s1_i;
        s2_j    <= s1_j;
      end
    end
  end

  // Result register: a new result replaces an accepted one on the same edge
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      c_data    <= '0;
      c_i       <= '0;
      c_j       <= '0;
    end else if (adv) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid && s2_last) begin
        c_data <= acc;
        c_i    <= s2_i;
        c_j    <= s2_j;
      end
    end
  end

  // Expected-k tracking; mismatches are sticky and the counter resyncs to k+1
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      exp_k   <= '0;
      seq_err <= 1'b0;
    end else if (accept) begin
      exp_k <= k_next;
      if ((k != exp_k) || restart_err) seq_err <= 1'b1;
    end
  end

  // Result counter and end-of-matrix pulse
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      res_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        if (res_cnt == WIDTH_BIT'(NRES - 1)) begin
          res_cnt <= '0;
          done    <= 1'b1;
        end else begin
          res_cnt <= res_cnt + 1'b1;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // FSM next state; leaving HOLD picks ACCUM if a partial sum is still open
  always_comb begin
    state_next = state;
    if (out_valid && !out_ready) begin
      state_next = ST_HOLD;
    end else begin
      unique case (state)
        ST_IDLE:  if (accept && (k == '0) && !last_in) state_next = ST_ACCUM;
        ST_ACCUM: if (accept && last_in) state_next = ST_IDLE;
        ST_HOLD: begin
          if (accept) state_next = last_in ? ST_IDLE : ST_ACCUM;
          else        state_next = (exp_k != '0) ? ST_ACCUM : ST_IDLE;
        end
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: flag a k==0 beat that abandons a live partial sum
  always_comb begin
    restart_err = 1'b0;
    if (accept && (k == '0)) begin
      restart_err = (state == ST_ACCUM) || ((state == ST_HOLD) && (exp_k != '0));
    end
  end

endmodule
